// File: rtl/fbe_cfg_ctrl.sv
// fbe_cfg_ctrl: runtime configuration sequencer for the filter-bank/echo datapath.
// Closes the input stream at a packet boundary, reloads LP/BP/HP filters one by one, then reopens it.
module fbe_cfg_ctrl #(
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TO_WIDTH       = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                  pi_clk,
  input  logic                  pi_sreset,
  input  logic                  pi_cfg_start,
  input  logic [2:0]            pi_cfg_mask,
  input  logic [9:0]            pi_lp_order,
  input  logic [9:0]            pi_bp_order,
  input  logic [9:0]            pi_hp_order,
  output logic [9:0]            po_lp_order,
  output logic [9:0]            po_bp_order,
  output logic [9:0]            po_hp_order,
  output logic                  po_lp_coeff_init,
  output logic                  po_bp_coeff_init,
  output logic                  po_hp_coeff_init,
  input  logic                  pi_cf_lddone_lp,
  input  logic                  pi_cf_lddone_bp,
  input  logic                  pi_cf_lddone_hp,
  input  logic                  pi_cfnum_err_lp,
  input  logic                  pi_cfnum_err_bp,
  input  logic                  pi_cfnum_err_hp,
  input  logic [DATA_WIDTH-1:0] pi_data,
  input  logic                  pi_valid,
  input  logic                  pi_last,
  output logic                  po_ready,
  output logic [DATA_WIDTH-1:0] po_data,
  output logic                  po_valid,
  output logic                  po_last,
  input  logic                  pi_ready,
  output logic                  po_busy,
  output logic                  po_done,
  output logic [2:0]            po_err,
  output logic                  po_timeout
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRAIN = 3'd1,
    S_SEL   = 3'd2,
    S_INIT  = 3'd3,
    S_WAIT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                r_state;
  state_t                w_next;
  logic                  r_in_pkt;
  logic [2:0]            r_rem;
  logic [2:0]            r_sel;
  logic [9:0]            r_lp_sh;
  logic [9:0]            r_bp_sh;
  logic [9:0]            r_hp_sh;
  logic [9:0]            r_lp_ord;
  logic [9:0]            r_bp_ord;
  logic [9:0]            r_hp_ord;
  logic [2:0]            r_init;
  logic [TO_WIDTH-1:0]   r_cnt;
  logic                  r_busy;
  logic                  r_done;
  logic [2:0]            r_err;
  logic                  r_timeout;

  logic                  w_open;
  logic                  w_hs;
  logic                  w_accept;
  logic                  w_ld_sel;
  logic                  w_cferr_sel;
  logic                  w_to_hit;
  logic [2:0]            w_rem_nxt;
  logic [2:0]            w_err_nxt;
  logic                  w_to_nxt;
  logic [2:0]            w_pick;
  logic [2:0]            w_init_nxt;

  // Lowest set bit wins, giving the fixed LP -> BP -> HP load order.
  function automatic logic [2:0] f_lowest(input logic [2:0] v);
    logic [2:0] r;
    if (v[0]) begin
      r = 3'b001;
    end else if (v[1]) begin
      r = 3'b010;
    end else if (v[2]) begin
      r = 3'b100;
    end else begin
      r = 3'b000;
    end
    return r;
  endfunction

  // Zero-latency stream gate; it may only close between packets.
  assign w_open   = (r_state == S_IDLE) | ((r_state == S_DRAIN) & r_in_pkt);
  assign po_data  = pi_data;
  assign po_last  = pi_last;
  assign po_valid = pi_valid & w_open;
  assign po_ready = pi_ready & w_open;
  assign w_hs     = pi_valid & pi_ready & w_open;

  assign w_accept    = (r_state == S_IDLE) & pi_cfg_start;
  assign w_ld_sel    = |(r_sel & {pi_cf_lddone_hp, pi_cf_lddone_bp, pi_cf_lddone_lp});
  assign w_cferr_sel = |(r_sel & {pi_cfnum_err_hp, pi_cfnum_err_bp, pi_cfnum_err_lp});
  assign w_to_hit    = (r_cnt == TO_LAST);

  assign po_lp_order      = r_lp_ord;
  assign po_bp_order      = r_bp_ord;
  assign po_hp_order      = r_hp_ord;
  assign po_lp_coeff_init = r_init[0];
  assign po_bp_coeff_init = r_init[1];
  assign po_hp_coeff_init = r_init[2];
  assign po_busy          = r_busy;
  assign po_done          = r_done;
  assign po_err           = r_err;
  assign po_timeout       = r_timeout;

  // FSM state register.
  always_ff @(posedge pi_clk) begin
    if (pi_sreset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (pi_cfg_start) begin
          w_next = S_DRAIN;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (!r_in_pkt) begin
          w_next = S_SEL;
        end else begin
          w_next = S_DRAIN;
        end
      end
      S_SEL: begin
        if (r_sel == 3'b000) begin
          w_next = S_DONE;
        end else begin
          w_next = S_INIT;
        end
      end
      S_INIT: begin
        w_next = S_WAIT;
      end
      S_WAIT: begin
        if (w_ld_sel || w_to_hit) begin
          w_next = S_SEL;
        end else begin
          w_next = S_WAIT;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // FSM output logic: next values of the registered status, selection and strobes.
  always_comb begin
    w_rem_nxt = r_rem;
    w_err_nxt = r_err;
    w_to_nxt  = r_timeout;
    case (r_state)
      S_IDLE: begin
        if (pi_cfg_start) begin
          w_rem_nxt = pi_cfg_mask;
          w_err_nxt = 3'b000;
          w_to_nxt  = 1'b0;
        end else begin
          w_rem_nxt = r_rem;
        end
      end
      S_WAIT: begin
        // A load-done in the timeout cycle still counts as a normal completion.
        if (w_ld_sel) begin
          w_err_nxt = r_err | (r_sel & {3{w_cferr_sel}});
          w_rem_nxt = r_rem & ~r_sel;
        end else if (w_to_hit) begin
          w_err_nxt = r_err | r_sel;
          w_to_nxt  = 1'b1;
          w_rem_nxt = r_rem & ~r_sel;
        end else begin
          w_rem_nxt = r_rem;
        end
      end
      default: begin
        w_rem_nxt = r_rem;
      end
    endcase
    w_pick = f_lowest(w_rem_nxt);
    if ((r_state == S_SEL) && (w_next == S_INIT)) begin
      w_init_nxt = r_sel;
    end else begin
      w_init_nxt = 3'b000;
    end
  end

  // Packet tracking on the gated handshake.
  always_ff @(posedge pi_clk) begin
    if (pi_sreset) begin
      r_in_pkt <= 1'b0;
    end else if (w_hs) begin
      r_in_pkt <= ~pi_last;
    end else begin
      r_in_pkt <= r_in_pkt;
    end
  end

  // Shadow orders captured on an accepted start.
  always_ff @(posedge pi_clk) begin
    if (pi_sreset) begin
      r_lp_sh <= 10'd0;
      r_bp_sh <= 10'd0;
      r_hp_sh <= 10'd0;
    end else if (w_accept) begin
      r_lp_sh <= pi_lp_order;
      r_bp_sh <= pi_bp_order;
      r_hp_sh <= pi_hp_order;
    end else begin
      r_lp_sh <= r_lp_sh;
      r_bp_sh <= r_bp_sh;
      r_hp_sh <= r_hp_sh;
    end
  end

  // Selection and order outputs load on entry to SEL, a full cycle ahead of the init strobe.
  always_ff @(posedge pi_clk) begin
    if (pi_sreset) begin
      r_sel    <= 3'b000;
      r_lp_ord <= 10'd0;
      r_bp_ord <= 10'd0;
      r_hp_ord <= 10'd0;
    end else if (w_next == S_SEL) begin
      r_sel <= w_pick;
      if (w_pick[0]) r_lp_ord <= r_lp_sh;
      if (w_pick[1]) r_bp_ord <= r_bp_sh;
      if (w_pick[2]) r_hp_ord <= r_hp_sh;
    end else begin
      r_sel <= r_sel;
    end
  end

  // Remaining mask, status, strobes and the load-done timeout counter.
  always_ff @(posedge pi_clk) begin
    if (pi_sreset) begin
      r_rem     <= 3'b000;
      r_err     <= 3'b000;
      r_timeout <= 1'b0;
      r_init    <= 3'b000;
      r_cnt     <= {TO_WIDTH{1'b0}};
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_rem     <= w_rem_nxt;
      r_err     <= w_err_nxt;
      r_timeout <= w_to_nxt;
      r_init    <= w_init_nxt;
      r_busy    <= (w_next != S_IDLE);
      r_done    <= (w_next == S_DONE);
      if (r_state == S_INIT) begin
        r_cnt <= {TO_WIDTH{1'b0}};
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt + TO_WIDTH'(1);
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

endmodule
